// File: rtl/alu_wb_buffer.sv
// ALU result buffer: small FIFO between ALU issue and the writeback/commit port, with flush.
// Optional zero-latency empty-buffer bypass when ALU_WB_BYPASS_EN is defined.

package riscv;
   localparam int unsigned XLEN = 64;
endpackage

module alu_wb_buffer #(
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned TRANS_ID_BITS = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     alu_valid_i,
   output logic                     alu_ready_o,
   input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
   input  logic [riscv::XLEN-1:0]   alu_result_i,
   input  logic                     alu_branch_res_i,
   output logic                     wb_valid_o,
   input  logic                     wb_ready_i,
   output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
   output logic [riscv::XLEN-1:0]   wb_result_o,
   output logic                     wb_branch_res_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [riscv::XLEN-1:0]   result;
      logic                     branch_res;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               empty, full;
   logic               push, pop;
   entry_t             wdata;
   entry_t             head;
   entry_t             wb_entry;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign wdata = '{trans_id: alu_trans_id_i, result: alu_result_i, branch_res: alu_branch_res_i};
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

   // Ready depends on stored occupancy only, so a full buffer never accepts even on a pop.
   assign alu_ready_o = ~full;

`ifdef ALU_WB_BYPASS_EN
   logic bypass;
   // Empty buffer and a ready consumer: hand the ALU result straight through.
   assign bypass     = empty & alu_valid_i & wb_ready_i & ~flush_i;
   assign push       = alu_valid_i & alu_ready_o & ~bypass;
   assign wb_entry   = bypass ? wdata : head;
   assign wb_valid_o = ~empty | bypass;
`else
   assign push       = alu_valid_i & alu_ready_o;
   assign wb_entry   = head;
   assign wb_valid_o = ~empty;
`endif

   // Pops only drain stored entries; a bypassed result never touches the pointers.
   assign pop = ~empty & wb_ready_i;

   assign wb_trans_id_o   = wb_entry.trans_id;
   assign wb_result_o     = wb_entry.result;
   assign wb_branch_res_o = wb_entry.branch_res;

   // Storage array.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers and occupancy; flush wins over any same-cycle push or pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && full));
   a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= CNT_W'(DEPTH));
   a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (wb_valid_o && !wb_ready_i && !flush_i) |=>
         ($stable(wb_trans_id_o) && $stable(wb_result_o) && $stable(wb_branch_res_o)));
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: queue reference model, negedge monitor, directed + random stimulus.
module tb_alu_wb_buffer;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned TIDW  = 3;
   localparam int unsigned XLEN  = riscv::XLEN;

   typedef struct {
      logic [TIDW-1:0] id;
      logic [XLEN-1:0] res;
      logic            br;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            alu_valid = 1'b0;
   logic            alu_ready_o;
   logic [TIDW-1:0] alu_id = '0;
   logic [XLEN-1:0] alu_res = '0;
   logic            alu_br = 1'b0;
   logic            wb_valid_o;
   logic            wb_ready = 1'b0;
   logic [TIDW-1:0] wb_trans_id_o;
   logic [XLEN-1:0] wb_result_o;
   logic            wb_branch_res_o;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t            mq[$];
   logic [TIDW-1:0] popped_ids[$];

   alu_wb_buffer #(.DEPTH(DEPTH), .TRANS_ID_BITS(TIDW)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .flush_i         (flush),
      .alu_valid_i     (alu_valid),
      .alu_ready_o     (alu_ready_o),
      .alu_trans_id_i  (alu_id),
      .alu_result_i    (alu_res),
      .alu_branch_res_i(alu_br),
      .wb_valid_o      (wb_valid_o),
      .wb_ready_i      (wb_ready),
      .wb_trans_id_o   (wb_trans_id_o),
      .wb_result_o     (wb_result_o),
      .wb_branch_res_o (wb_branch_res_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the buffer is an ordered queue of at most DEPTH results.
   always @(posedge clk or negedge rst_n) begin
      bit   byp;
      bit   room;
      exp_t e;
      if (!rst_n) begin
         mq.delete();
      end else if (flush) begin
         mq.delete();
      end else begin
         byp = 1'b0;
`ifdef ALU_WB_BYPASS_EN
         byp = (mq.size() == 0) && alu_valid && wb_ready;
`endif
         room = (mq.size() < DEPTH);
         if (mq.size() != 0 && wb_ready) void'(mq.pop_front());
         if (alu_valid && room && !byp) begin
            e.id = alu_id; e.res = alu_res; e.br = alu_br;
            mq.push_back(e);
         end
      end
   end

   // Monitor: compare what the DUT presents against the model, away from the clock edge.
   always @(negedge clk) begin
      exp_t e;
      bit   ev;
      if (!rst_n) begin
         check("rst_wb_valid", XLEN'(wb_valid_o), '0);
         check("rst_wb_result", wb_result_o, '0);
         check("rst_wb_id", XLEN'(wb_trans_id_o), '0);
      end else begin
         ev = 1'b0;
         e.id = '0; e.res = '0; e.br = 1'b0;
         if (mq.size() != 0) begin
            ev = 1'b1;
            e  = mq[0];
         end
`ifdef ALU_WB_BYPASS_EN
         else if (alu_valid && wb_ready && !flush) begin
            ev = 1'b1;
            e.id = alu_id; e.res = alu_res; e.br = alu_br;
         end
`endif
         check("alu_ready", XLEN'(alu_ready_o), XLEN'(mq.size() < DEPTH));
         check("wb_valid", XLEN'(wb_valid_o), XLEN'(ev));
         check("wb_trans_id", XLEN'(wb_trans_id_o), XLEN'(e.id));
         check("wb_result", wb_result_o, e.res);
         check("wb_branch_res", XLEN'(wb_branch_res_o), XLEN'(e.br));
         if (wb_valid_o && wb_ready && !flush) popped_ids.push_back(wb_trans_id_o);
      end
   end

   task automatic cyc(input logic v, input logic [TIDW-1:0] id, input logic [XLEN-1:0] res,
                      input logic br, input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      alu_valid = v; alu_id = id; alu_res = res; alu_br = br;
      wb_ready = rdy; flush = fl;
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      int n5;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", XLEN'(wb_valid_o), '0);
      check("reset_result", wb_result_o, '0);
      rst_n = 1'b1;
      #1;
      check("post_reset_ready", XLEN'(alu_ready_o), XLEN'(1));
      idle(1'b1, 2);

      // single pass-through
      cyc(1'b1, 3'd3, XLEN'(64'h1234), 1'b1, 1'b1, 1'b0);
      idle(1'b1, 3);

      // fill and back-pressure
      cyc(1'b1, 3'd1, XLEN'(64'hAAAA), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'd2, XLEN'(64'hBBBB), 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 3'd7, XLEN'(64'hCCCC), 1'b1, 1'b0, 1'b0);
      idle(1'b0, 5);
      popped_ids.delete();
      idle(1'b1, 3);
      check("bp_pop_count", XLEN'(popped_ids.size()), XLEN'(2));
      if (popped_ids.size() == 2) begin
         check("bp_first_id", XLEN'(popped_ids[0]), XLEN'(1));
         check("bp_second_id", XLEN'(popped_ids[1]), XLEN'(2));
      end

      // streaming with pointer wrap
      popped_ids.delete();
      for (int i = 0; i < 8; i++)
         cyc(1'b1, TIDW'(i), {$urandom(), $urandom()}, 1'($urandom()), 1'b1, 1'b0);
      idle(1'b1, 3);
      check("stream_count", XLEN'(popped_ids.size()), XLEN'(8));
      for (int i = 0; i < 8 && i < popped_ids.size(); i++)
         check("stream_order", XLEN'(popped_ids[i]), XLEN'(i));

      // flush with a simultaneous push of id 5
      cyc(1'b1, 3'd1, XLEN'(64'h11), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'd2, XLEN'(64'h22), 1'b0, 1'b0, 1'b0);
      idle(1'b0, 1);
      popped_ids.delete();
      cyc(1'b1, 3'd5, XLEN'(64'h55), 1'b1, 1'b1, 1'b1);
      idle(1'b1, 1);
      #1;
      check("flush_valid", XLEN'(wb_valid_o), '0);
      check("flush_ready", XLEN'(alu_ready_o), XLEN'(1));
      idle(1'b1, 2);
      n5 = 0;
      foreach (popped_ids[i]) if (popped_ids[i] == 3'd5) n5++;
      check("flush_id5_absent", XLEN'(n5), '0);

      // asynchronous reset while full and stalled
      cyc(1'b1, 3'd4, XLEN'(64'h44), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'd6, XLEN'(64'h66), 1'b1, 1'b0, 1'b0);
      idle(1'b0, 1);
      #2;
      check("full_before_reset", XLEN'(wb_valid_o), XLEN'(1));
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", XLEN'(wb_valid_o), '0);
      check("async_reset_result", wb_result_o, '0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      check("after_reset_ready", XLEN'(alu_ready_o), XLEN'(1));
      check("after_reset_valid", XLEN'(wb_valid_o), '0);

      // randomized traffic
      for (int i = 0; i < 800; i++)
         cyc(1'($urandom_range(0, 99) < 60), TIDW'($urandom()), {$urandom(), $urandom()},
             1'($urandom()), 1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 3));
      idle(1'b1, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
